// File: rtl/seg7_enc.sv
// Seven-segment pair decoder: samples two active-low digit patterns, debounces them and
// emits a registered digit pair over a valid/ready handshake. Optional macro: SEG7_ENC_ERRCNT_EN.
module seg7_enc #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] nSEGUP,
  input  logic [6:0] nSEGLOW,
  output logic [2:0] doutup,
  output logic [3:0] doutlow,
  output logic       dvalid,
  input  logic       dready,
  output logic       err,
`ifdef SEG7_ENC_ERRCNT_EN
  output logic [7:0] errcnt,
`endif
  output logic [1:0] dbg_state
);

  // Handshake: dvalid rises only in HOLD with doutup/doutlow frozen; the pair is consumed at
  // the rising edge where dvalid and dready are both high, and dvalid drops at that edge.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [13:0] BLANK = 14'h3fff;
  localparam logic [7:0]  LIMIT = 8'(STABLE_CYCLES - 2);

  state_t      state_q, state_d;
  logic [13:0] sample_q, sample_d;
  logic [13:0] ref_q, ref_d;
  logic [13:0] last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  up_q, up_d;
  logic [3:0]  low_q, low_d;
  logic        dvalid_q, dvalid_d;
  logic        err_q, err_d;
  logic [4:0]  up_dec, low_dec;
  logic        legal;
  logic        stable;

  // Returns {legal, digit}.
  function automatic logic [4:0] dec(input logic [6:0] p);
    case (p)
      7'b1000000: dec = {1'b1, 4'd0};
      7'b1111001: dec = {1'b1, 4'd1};
      7'b0100100: dec = {1'b1, 4'd2};
      7'b0110000: dec = {1'b1, 4'd3};
      7'b0011001: dec = {1'b1, 4'd4};
      7'b0010010: dec = {1'b1, 4'd5};
      7'b0000010: dec = {1'b1, 4'd6};
      7'b1011000: dec = {1'b1, 4'd7};
      7'b0000000: dec = {1'b1, 4'd8};
      7'b0010000: dec = {1'b1, 4'd9};
      default:    dec = {1'b0, 4'd0};
    endcase
  endfunction

  always_comb begin
    sample_d = {nSEGUP, nSEGLOW};
    state_d  = state_q;
    ref_d    = ref_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    up_d     = up_q;
    low_d    = low_q;
    dvalid_d = dvalid_q;
    err_d    = 1'b0;
    up_dec   = dec(sample_q[13:7]);
    low_dec  = dec(sample_q[6:0]);
    legal    = up_dec[4] && low_dec[4] && (up_dec[3:0] <= 4'd5);
    stable   = (sample_q == ref_q);

    case (state_q)
      IDLE: begin
        if (sample_q != last_q) begin
          state_d = SETTLE;
          ref_d   = sample_q;
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        if (!stable) begin
          ref_d = sample_q;
          cnt_d = 8'd0;
        end else if (cnt_q >= LIMIT) begin
          // ref_q was first seen one edge before the counter started, so this edge is the
          // STABLE_CYCLES-th consecutive identical sample.
          if (sample_q == last_q) begin
            state_d = IDLE;
          end else if (legal) begin
            up_d     = up_dec[2:0];
            low_d    = low_dec[3:0];
            dvalid_d = 1'b1;
            last_d   = sample_q;
            state_d  = HOLD;
          end else begin
            err_d   = 1'b1;
            last_d  = sample_q;
            state_d = IDLE;
          end
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (dready) begin
          dvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sample_q <= BLANK;
      ref_q    <= BLANK;
      last_q   <= BLANK;
      cnt_q    <= 8'd0;
      up_q     <= 3'd0;
      low_q    <= 4'd0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      ref_q    <= ref_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      up_q     <= up_d;
      low_q    <= low_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
    end
  end

`ifdef SEG7_ENC_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != 8'hff)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) errcnt_q <= 8'd0;
    else     errcnt_q <= errcnt_d;
  end

  assign errcnt = errcnt_q;
`endif

  assign doutup    = up_q;
  assign doutlow   = low_q;
  assign dvalid    = dvalid_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
